// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with relative branch and a
// hardware return-address stack (RAS).
//
// Ops (highest priority first, only one executes per cycle):
//   pc_ret  : PC <= most recent return address, pop (holds and flags
//             ras_udf when the stack is empty)
//   pc_call : push PC + STEP, PC <= PC_in (overwrites the oldest entry
//             and flags ras_ovf when the stack is full)
//   pc_ld   : PC <= PC_in
//   pc_br   : PC <= PC + BR_off
//   pc_inc  : PC <= PC + STEP
//   none    : hold
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   pc_inc/ld/br/call/ret op strobes
//   ras_clr               clears the sticky ras_ovf / ras_udf flags
//   PC_in                 jump / call target
//   BR_off                two's-complement branch offset
//   PC_out                registered program counter
//   ras_empty, ras_full   decoded from the registered stack count
//   ras_ovf, ras_udf      sticky overflow / underflow flags
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.

module pc_unit #(
    parameter int unsigned        WIDTH     = 32,
    parameter int unsigned        STEP      = 4,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter int unsigned        RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pc_inc,
    input  logic             pc_ld,
    input  logic             pc_br,
    input  logic             pc_call,
    input  logic             pc_ret,
    input  logic             ras_clr,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [WIDTH-1:0] BR_off,
    output logic [WIDTH-1:0] PC_out,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_udf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;   // next slot to write
    logic [CNT_W-1:0] cnt_q, cnt_d;   // valid entries, saturates at RAS_DEPTH
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // Stack storage is intentionally not reset; it is only read when
    // cnt_q is non-zero.
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [PTR_W-1:0] top_ptr;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CNT_MAX);
    // The pointer wraps naturally because RAS_DEPTH is a power of two.
    assign top_ptr  = ptr_q - PTR_W'(1);
    assign wr_data  = pc_q + WIDTH'(STEP);

    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        wr_en = 1'b0;
        // Clear first so that a flag-setting event below overrides it.
        ovf_d = ras_clr ? 1'b0 : ovf_q;
        udf_d = ras_clr ? 1'b0 : udf_q;

        if (pc_ret) begin
            if (is_empty) begin
                udf_d = 1'b1;
            end else begin
                pc_d  = ras_mem_q[top_ptr];
                ptr_d = top_ptr;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (pc_call) begin
            // When full, ptr_q already points at the oldest entry, so the
            // write naturally evicts it.
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            pc_d  = PC_in;
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pc_ld) begin
            pc_d = PC_in;
        end else if (pc_br) begin
            pc_d = pc_q + BR_off;
        end else if (pc_inc) begin
            pc_d = pc_q + WIDTH'(STEP);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q  <= RESET_VEC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // A reset cycle discards the op, including any push.
    always_ff @(posedge CLK) begin
        if (!RESET && wr_en) begin
            ras_mem_q[ptr_q] <= wr_data;
        end
    end

    assign PC_out    = pc_q;
    assign ras_empty = is_empty;
    assign ras_full  = is_full;
    assign ras_ovf   = ovf_q;
    assign ras_udf   = udf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit. A second instance with RESET_VEC = 0x100
// shares all inputs to cover the reset vector parameter.

module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        pc_inc, pc_ld, pc_br, pc_call, pc_ret, ras_clr;
    logic [31:0] pc_in, br_off;
    logic [31:0] pc_out, pc_out_b;
    logic        ras_empty, ras_full, ras_ovf, ras_udf;
    logic        ras_empty_b, ras_full_b, ras_ovf_b, ras_udf_b;

    int checks_total;
    int checks_passed;

    pc_unit #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
        .CLK(clk), .RESET(reset),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_br(pc_br),
        .pc_call(pc_call), .pc_ret(pc_ret), .ras_clr(ras_clr),
        .PC_in(pc_in), .BR_off(br_off), .PC_out(pc_out),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_udf(ras_udf)
    );

    pc_unit #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut_b (
        .CLK(clk), .RESET(reset),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_br(pc_br),
        .pc_call(pc_call), .pc_ret(pc_ret), .ras_clr(ras_clr),
        .PC_in(pc_in), .BR_off(br_off), .PC_out(pc_out_b),
        .ras_empty(ras_empty_b), .ras_full(ras_full_b),
        .ras_ovf(ras_ovf_b), .ras_udf(ras_udf_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers: inputs change #1 after the rising edge, outputs are
    // sampled at that same point, well away from the next edge.
    task automatic idle();
        pc_inc = 0; pc_ld = 0; pc_br = 0; pc_call = 0; pc_ret = 0; ras_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_ld(input logic [31:0] target);
        idle(); pc_ld = 1; pc_in = target; step(); idle();
    endtask

    task automatic do_call(input logic [31:0] target);
        idle(); pc_call = 1; pc_in = target; step(); idle();
    endtask

    task automatic do_ret();
        idle(); pc_ret = 1; step(); idle();
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        idle();
        pc_in  = '0;
        br_off = '0;
        reset  = 1'b1;
        #1;
        step();

        // Reset state
        chk("rst_pc",      pc_out,    32'h0);
        chk("rst_pc_vec",  pc_out_b,  32'h100);
        chk("rst_empty",   ras_empty, 1);
        chk("rst_full",    ras_full,  0);
        chk("rst_ovf",     ras_ovf,   0);
        chk("rst_udf",     ras_udf,   0);
        reset = 1'b0;

        // Increment
        pc_inc = 1;
        step(); chk("inc_1", pc_out, 32'h4);
        step(); chk("inc_2", pc_out, 32'h8);
        step(); chk("inc_3", pc_out, 32'hC);
        chk("inc_vec", pc_out_b, 32'h10C);
        idle();
        step(); chk("hold", pc_out, 32'hC);

        // Load, branch, wrap
        do_ld(32'h1000); chk("ld", pc_out, 32'h1000);
        pc_br = 1; br_off = 32'hFFFF_FFF0; step(); idle();
        chk("br_neg", pc_out, 32'h0FF0);
        pc_br = 1; br_off = 32'h0000_0020; step(); idle();
        chk("br_pos", pc_out, 32'h1010);
        do_ld(32'hFFFF_FFFC); chk("ld_top", pc_out, 32'hFFFF_FFFC);
        pc_inc = 1; step(); idle();
        chk("inc_wrap", pc_out, 32'h0);

        // Priority among ld/br/inc
        do_ld(32'h40);
        pc_ld = 1; pc_br = 1; pc_inc = 1; pc_in = 32'h200; br_off = 32'h10;
        step(); idle();
        chk("prio_ld", pc_out, 32'h200);
        pc_br = 1; pc_inc = 1; br_off = 32'h10; step(); idle();
        chk("prio_br", pc_out, 32'h210);

        // call + ret on empty stack: return wins, underflow, no push
        pc_call = 1; pc_ret = 1; pc_in = 32'h300; step(); idle();
        chk("cr_pc",    pc_out,    32'h210);
        chk("cr_udf",   ras_udf,   1);
        chk("cr_empty", ras_empty, 1);
        ras_clr = 1; step(); idle();
        chk("clr_udf", ras_udf, 0);
        // Set wins over clear in the same cycle
        ras_clr = 1; pc_ret = 1; step(); idle();
        chk("clr_set_wins", ras_udf, 1);
        ras_clr = 1; step(); idle();
        chk("clr_again", ras_udf, 0);

        // Nested call/return
        do_ld(32'h10);
        do_call(32'h100); chk("n_call1", pc_out, 32'h100);
        chk("n_nonempty", ras_empty, 0);
        do_call(32'h200); chk("n_call2", pc_out, 32'h200);
        do_ret(); chk("n_ret1", pc_out, 32'h104);
        do_ret(); chk("n_ret2", pc_out, 32'h14);
        chk("n_empty", ras_empty, 1);
        chk("n_udf",   ras_udf,   0);

        // Overflow
        do_ld(32'h0);
        do_call(32'h10);
        do_call(32'h20);
        do_call(32'h30);
        chk("o_notfull", ras_full, 0);
        do_call(32'h40);
        chk("o_full4", ras_full, 1);
        chk("o_ovf4",  ras_ovf,  0);
        do_call(32'h50);
        chk("o_pc5",   pc_out,   32'h50);
        chk("o_ovf5",  ras_ovf,  1);
        chk("o_full5", ras_full, 1);
        do_ret(); chk("o_ret1", pc_out, 32'h44);
        chk("o_notfull_ret", ras_full, 0);
        do_ret(); chk("o_ret2", pc_out, 32'h34);
        do_ret(); chk("o_ret3", pc_out, 32'h24);
        do_ret(); chk("o_ret4", pc_out, 32'h14);
        chk("o_empty", ras_empty, 1);
        chk("o_udf0",  ras_udf,   0);
        do_ret(); chk("o_ret5_hold", pc_out, 32'h14);
        chk("o_udf1", ras_udf, 1);
        ras_clr = 1; step(); idle();
        chk("o_clr_ovf", ras_ovf, 0);
        chk("o_clr_udf", ras_udf, 0);

        // Call immediately followed by return
        do_call(32'h500); chk("b2b_call", pc_out, 32'h500);
        do_ret();         chk("b2b_ret",  pc_out, 32'h18);

        // Reset mid-operation
        do_call(32'h600);
        do_call(32'h700);
        chk("r_pc_pre", pc_out, 32'h700);
        reset = 1; pc_ret = 1; step(); idle(); reset = 0;
        chk("r_pc",     pc_out,    32'h0);
        chk("r_pc_vec", pc_out_b,  32'h100);
        chk("r_empty",  ras_empty, 1);
        chk("r_udf0",   ras_udf,   0);
        do_ret();
        chk("r_ret_pc",  pc_out,  32'h0);
        chk("r_ret_udf", ras_udf, 1);
        chk("r_ret_udf_b", ras_udf_b, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter with relative branch and a hardware return-address stack (RAS). It is the successor to the fixed 32-bit load/increment PC and sits in the fetch stage of the CPU, driven by the control unit. It supports absolute load, relative branch, call (push return address) and return (pop), with saturating stack status and sticky error flags.

## Interface
- WIDTH, 32: PC and address width in bits.
- STEP, 4: increment added by pc_inc and used for the call return address.
- RESET_VEC, 0: PC value after reset.
- RAS_DEPTH, 4: return-address stack entries. Power of two, at least 2.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- pc_inc  input  1  PC_out <= PC_out + STEP.
- pc_ld  input  1  PC_out <= PC_in (absolute jump).
- pc_br  input  1  PC_out <= PC_out + BR_off (relative branch).
- pc_call  input  1  push PC_out + STEP, then PC_out <= PC_in.
- pc_ret  input  1  PC_out <= top of RAS, then pop.
- ras_clr  input  1  clears ras_ovf and ras_udf only.
- PC_in  input  WIDTH  jump or call target.
- BR_off  input  WIDTH  two's-complement branch offset.
- PC_out  output  WIDTH  current PC (registered).
- ras_empty  output  1  RAS count == 0.
- ras_full  output  1  RAS count == RAS_DEPTH.
- ras_ovf  output  1  sticky: a call was made while the RAS was full.
- ras_udf  output  1  sticky: a return was made while the RAS was empty.

## Operation
- Priority, highest first: pc_ret > pc_call > pc_ld > pc_br > pc_inc. Only the highest asserted op executes. No op asserted means hold.
- Arithmetic is modulo 2^WIDTH. PC_out + STEP and PC_out + BR_off wrap silently, for example 0xFFFFFFFC + 4 = 0x00000000.
- The RAS is a circular buffer with a top pointer (log2 RAS_DEPTH bits) and a saturating count (0..RAS_DEPTH).
- Call when not full:
  - write PC_out + STEP at the top pointer, advance the pointer, count +1;
  - PC_out <= PC_in.
- Call when full:
  - the write overwrites the oldest entry, the pointer advances, count stays RAS_DEPTH;
  - ras_ovf <= 1;
  - the PC still loads PC_in.
- Return when not empty: PC_out <= the most recently pushed entry, retreat the pointer, count -1.
- Return when empty: PC_out holds, pointer and count unchanged, ras_udf <= 1.
- After an overflow, returns yield the last RAS_DEPTH pushed addresses in LIFO order. Older ones are lost.
- ras_clr clears both sticky flags. If a flag-setting event happens in the same cycle, set wins.
- Stack contents are not cleared on reset. Only the pointer and count reset, and entries are never read while count is 0.

## Timing
- Reset, synchronous, takes priority over every op:
  - PC_out = RESET_VEC, pointer = 0, count = 0;
  - ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_udf = 0.
- RESET asserted mid-sequence (for example during a call) discards that cycle's op entirely.
- Every op takes 1 cycle. The new PC_out is visible after the edge on which the op is sampled.
- Back-to-back ops are allowed every cycle, including call immediately followed by return. A return in cycle N+1 sees the push from cycle N.
- ras_empty and ras_full are decoded from the registered count and are valid in the same cycle as PC_out. No combinational path from inputs to outputs.
- pc_call and pc_ret together in one cycle: the return executes and the call is ignored. Stack state changes only as a pop.

## Test plan
- Reset and increment: RESET high for 1 cycle, then pc_inc for 3 cycles -> PC_out = 0, 4, 8, 0xC. With RESET_VEC = 0x100, PC_out = 0x100 after reset.
- Load, branch and wrap:
  - pc_ld with PC_in = 0x1000 -> PC_out = 0x1000;
  - pc_br with BR_off = 0xFFFFFFF0 -> PC_out = 0x0FF0;
  - PC_out = 0xFFFFFFFC with pc_inc -> PC_out = 0x0.
- Priority: at PC 0x40, assert pc_ld, pc_br and pc_inc together with PC_in = 0x200 -> PC_out = 0x200. Assert pc_call and pc_ret together with an empty RAS -> PC_out holds, ras_udf = 1, count remains 0.
- Nested call/return:
  - at PC 0x10, call 0x100; at 0x100, call 0x200;
  - two returns -> PC_out = 0x104, then 0x14;
  - ras_empty = 1 afterwards and ras_udf = 0.
- Overflow (RAS_DEPTH = 4): 5 calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40 ->
  - ras_full = 1 after the 4th call, ras_ovf = 1 after the 5th;
  - 4 returns -> PC_out = 0x44, 0x34, 0x24, 0x14;
  - a 5th return -> PC_out holds at 0x14, ras_udf = 1;
  - ras_clr -> both flags 0.
- Reset mid-operation: after 2 calls, assert RESET on the same cycle as a pc_ret -> PC_out = RESET_VEC, ras_empty = 1. A following pc_ret sets ras_udf.
